// File: rtl/feedback_decoder.sv
// feedback_decoder: turns feedback bytes received by the UART into registered
// status flags, with link-liveness supervision and frame/error counters.
// Optional macro FEEDBACK_CONFIRM_EN: flags only update once two consecutive
// feedback frames carry the same payload.
//
// Byte handshake: a byte is taken once per rising edge of dataOut_valid;
// dataOut_bits must be stable on the cycle valid rises, and valid may stay
// high for any number of cycles without producing a second decode.
module feedback_decoder #(
    parameter int TIMEOUT_CYCLES = 153600,
    parameter int TMR_W          = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       script_mode,
    input  logic [7:0] dataOut_bits,
    input  logic       dataOut_valid,
    output logic       traveler_in_front_of_target_machine,
    output logic       traveler_has_item_in_hand,
    output logic       target_machine_is_processing,
    output logic       target_machine_has_item,
    output logic       status_update,
    output logic       link_alive,
    output logic [7:0] frame_count,
    output logic [7:0] error_count
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic             first_q;
    logic             valid_q;
    logic             strobe_q;
    logic [7:0]       byte_q;
    logic [3:0]       flags_q, flags_d;
    logic             status_q, status_d;
    logic             alive_q, alive_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0]       frames_q, frames_d;
    logic [7:0]       errors_q, errors_d;

    logic             rise;
    logic             frame_ok;
    logic             malformed;
    logic             expire;
    logic             load_flags;

    // first_q masks the cycle right after reset so a valid already high at
    // release is absorbed into the edge register instead of being decoded.
    assign rise = dataOut_valid && !valid_q && !first_q && !script_mode;

    // Edge detect and capture of the strobed byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_q  <= 1'b1;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            first_q  <= 1'b0;
            valid_q  <= dataOut_valid;
            strobe_q <= rise;
            if (rise) begin
                byte_q <= dataOut_bits;
            end
        end
    end

    assign frame_ok  = strobe_q && (byte_q[1:0] == 2'b01) && (byte_q[7:6] == 2'b00);
    assign malformed = strobe_q && (byte_q[1:0] == 2'b01) && (byte_q[7:6] != 2'b00);
    // A frame on the expiry cycle keeps the link alive.
    assign expire    = alive_q && (tmr_q == TMR_LAST) && !frame_ok;

`ifdef FEEDBACK_CONFIRM_EN
    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } confirm_state_e;

    confirm_state_e state_q, state_d;
    logic [3:0]     cand_q, cand_d;

    assign load_flags = frame_ok && (state_q == ST_PENDING) && (byte_q[5:2] == cand_q);

    // Confirm FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            cand_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
        end
    end

    // Confirm FSM next state: a payload must be seen twice in a row.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        case (state_q)
            ST_EMPTY: begin
                if (frame_ok) begin
                    state_d = ST_PENDING;
                    cand_d  = byte_q[5:2];
                end
            end
            ST_PENDING: begin
                if (frame_ok) begin
                    if (byte_q[5:2] == cand_q) begin
                        state_d = ST_EMPTY;
                    end else begin
                        cand_d = byte_q[5:2];
                    end
                end else if (malformed || expire) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end
`else
    assign load_flags = frame_ok;
`endif

    // Status, liveness and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q  <= 4'h0;
            status_q <= 1'b0;
            alive_q  <= 1'b0;
            tmr_q    <= '0;
            frames_q <= 8'h00;
            errors_q <= 8'h00;
        end else begin
            flags_q  <= flags_d;
            status_q <= status_d;
            alive_q  <= alive_d;
            tmr_q    <= tmr_d;
            frames_q <= frames_d;
            errors_q <= errors_d;
        end
    end

    // Next-state for flags, timeout and counters.
    always_comb begin
        flags_d  = flags_q;
        status_d = 1'b0;
        alive_d  = alive_q;
        tmr_d    = tmr_q;
        frames_d = frames_q;
        errors_d = errors_q;

        if (frame_ok) begin
            tmr_d    = '0;
            alive_d  = 1'b1;
            frames_d = frames_q + 8'd1;
        end else if (expire) begin
            alive_d  = 1'b0;
            tmr_d    = '0;
            flags_d  = 4'h0;
            status_d = 1'b1;
        end else if (alive_q) begin
            tmr_d = tmr_q + TMR_W'(1);
        end else begin
            tmr_d = '0;
        end

        if (load_flags) begin
            flags_d  = byte_q[5:2];
            status_d = 1'b1;
        end

        if (malformed && (errors_q != 8'hFF)) begin
            errors_d = errors_q + 8'd1;
        end
    end

    assign traveler_in_front_of_target_machine = flags_q[0];
    assign traveler_has_item_in_hand           = flags_q[1];
    assign target_machine_is_processing        = flags_q[2];
    assign target_machine_has_item             = flags_q[3];
    assign status_update                       = status_q;
    assign link_alive                          = alive_q;
    assign frame_count                         = frames_q;
    assign error_count                         = errors_q;

endmodule

// File: tb/tb_feedback_decoder.sv
// Bench for feedback_decoder with a short timeout; the reference model keeps
// link state as timestamps of accepted frames rather than a cycle counter.
module tb_feedback_decoder;

    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       script_mode;
    logic [7:0] dataOut_bits;
    logic       dataOut_valid;
    logic       f_front, f_hand, f_proc, f_item;
    logic       status_update;
    logic       link_alive;
    logic [7:0] frame_count;
    logic [7:0] error_count;
    logic [3:0] flags;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int su_cnt = 0;

    feedback_decoder #(.TIMEOUT_CYCLES(TO), .TMR_W(5)) dut (
        .clock                               (clock),
        .reset                               (reset),
        .script_mode                         (script_mode),
        .dataOut_bits                        (dataOut_bits),
        .dataOut_valid                       (dataOut_valid),
        .traveler_in_front_of_target_machine (f_front),
        .traveler_has_item_in_hand           (f_hand),
        .target_machine_is_processing        (f_proc),
        .target_machine_has_item             (f_item),
        .status_update                       (status_update),
        .link_alive                          (link_alive),
        .frame_count                         (frame_count),
        .error_count                         (error_count)
    );

    assign flags = {f_item, f_proc, f_hand, f_front};

    // Clock and edge/pulse bookkeeping.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (status_update) su_cnt <= su_cnt + 1;

    // ---------------- reference model ----------------
    logic [3:0] m_flags  = 4'h0;
    logic       m_alive  = 1'b0;
    logic [7:0] m_frames = 8'h00;
    logic [7:0] m_errors = 8'h00;
    logic       m_pend   = 1'b0;
    logic [3:0] m_cand   = 4'h0;
    int         m_last   = 0;
    int         m_pulses[$];

    // Link dies TO edges after the last accepted frame if nothing refreshed it.
    function automatic void m_expire(input int e);
        if (m_alive && (m_last + TO <= e)) begin
            m_alive = 1'b0;
            m_flags = 4'h0;
            m_pend  = 1'b0;
            m_pulses.push_back(m_last + TO);
        end
    endfunction

    // Byte whose decode takes effect at edge e.
    function automatic void m_byte(input logic [7:0] b, input int e);
        if (b[1:0] != 2'b01) return;
        if (b[7:6] != 2'b00) begin
            m_expire(e);
            if (m_errors != 8'hFF) m_errors = m_errors + 8'd1;
            m_pend = 1'b0;
            return;
        end
        m_expire(e - 1);
        m_frames = m_frames + 8'd1;
        m_alive  = 1'b1;
        m_last   = e;
`ifdef FEEDBACK_CONFIRM_EN
        if (m_pend && (b[5:2] == m_cand)) begin
            m_flags = b[5:2];
            m_pend  = 1'b0;
            m_pulses.push_back(e);
        end else begin
            m_pend = 1'b1;
            m_cand = b[5:2];
        end
`else
        m_flags = b[5:2];
        m_pulses.push_back(e);
`endif
    endfunction

    function automatic void m_reset(input int e);
        m_expire(e - 1);
        m_flags = 4'h0; m_alive = 1'b0; m_frames = 8'h00;
        m_errors = 8'h00; m_pend = 1'b0;
    endfunction

    function automatic int m_pulses_upto(input int e);
        int n = 0;
        foreach (m_pulses[i]) if (m_pulses[i] <= e) n++;
        return n;
    endfunction

    // ---------------- drivers (enter and leave on a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input int hold);
        dataOut_bits  = b;
        dataOut_valid = 1'b1;
        if (!script_mode) m_byte(b, cyc + 2);
        repeat (hold) @(negedge clock);
        dataOut_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset(cyc + 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; script_mode = 1'b0; dataOut_bits = 8'h00; dataOut_valid = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
        total++; if (status_update !== 1'b0) begin bad++; $display("FAIL reset_su: got %b want 0", status_update); end
        total++; if (link_alive !== 1'b0) begin bad++; $display("FAIL reset_alive: got %b want 0", link_alive); end
        total++; if (frame_count !== 8'h00) begin bad++; $display("FAIL reset_frames: got %0d want 0", frame_count); end
        total++; if (error_count !== 8'h00) begin bad++; $display("FAIL reset_errors: got %0d want 0", error_count); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_hold_decode();
        send_byte(8'h3D, 3);
        m_expire(cyc);
        total++; if (flags !== m_flags) begin bad++; $display("FAIL hold_flags: got %b want %b", flags, m_flags); end
        total++; if (frame_count !== m_frames) begin bad++; $display("FAIL hold_frames: got %0d want %0d", frame_count, m_frames); end
        total++; if (link_alive !== m_alive) begin bad++; $display("FAIL hold_alive: got %b want %b", link_alive, m_alive); end
        total++; if (su_cnt !== m_pulses_upto(cyc - 1)) begin bad++; $display("FAIL hold_pulses: got %0d want %0d", su_cnt, m_pulses_upto(cyc - 1)); end
    endtask

    task automatic test_script_mode();
        script_mode = 1'b1;
        send_byte(8'h05, 2);
        script_mode = 1'b0;
        m_expire(cyc);
        total++; if (flags !== m_flags) begin bad++; $display("FAIL script_flags: got %b want %b", flags, m_flags); end
        total++; if (frame_count !== m_frames) begin bad++; $display("FAIL script_frames: got %0d want %0d", frame_count, m_frames); end
        total++; if (error_count !== m_errors) begin bad++; $display("FAIL script_errors: got %0d want %0d", error_count, m_errors); end
        total++; if (link_alive !== m_alive) begin bad++; $display("FAIL script_alive: got %b want %b", link_alive, m_alive); end
    endtask

    task automatic test_malformed();
        logic [7:0] b;
        send_byte(8'hC1, 1);
        m_expire(cyc);
        total++; if (error_count !== m_errors) begin bad++; $display("FAIL malf_one: got %0d want %0d", error_count, m_errors); end
        total++; if (flags !== m_flags) begin bad++; $display("FAIL malf_flags: got %b want %b", flags, m_flags); end
        for (int i = 0; i < 300; i++) begin
            b = {2'($urandom_range(1, 3)), 4'($urandom), 2'b01};
            send_byte(b, 1);
        end
        m_expire(cyc);
        total++; if (error_count !== m_errors) begin bad++; $display("FAIL malf_sat: got %0d want %0d", error_count, m_errors); end
        total++; if (link_alive !== m_alive) begin bad++; $display("FAIL malf_alive: got %b want %b", link_alive, m_alive); end
    endtask

    task automatic test_timeout();
        int t0;
        send_byte(8'h09, 1);
        t0 = m_last;
        while (cyc < t0 + TO - 1) @(negedge clock);
        m_expire(cyc);
        total++; if (link_alive !== m_alive) begin bad++; $display("FAIL to_before: got %b want %b", link_alive, m_alive); end
        @(negedge clock);
        m_expire(cyc);
        total++; if (link_alive !== m_alive) begin bad++; $display("FAIL to_expire: got %b want %b", link_alive, m_alive); end
        total++; if (flags !== m_flags) begin bad++; $display("FAIL to_flags: got %b want %b", flags, m_flags); end
        total++; if (status_update !== (m_pulses_upto(cyc) != m_pulses_upto(cyc - 1))) begin
            bad++; $display("FAIL to_pulse: got %b want 1", status_update);
        end
        repeat (3) @(negedge clock);
        total++; if (su_cnt !== m_pulses_upto(cyc - 1)) begin bad++; $display("FAIL to_pulses: got %0d want %0d", su_cnt, m_pulses_upto(cyc - 1)); end
        // Revive, then land a frame exactly on the expiry edge.
        send_byte(8'h09, 1);
        t0 = m_last;
        while (cyc < t0 + TO - 2) @(negedge clock);
        send_byte(8'h09, 1);
        m_expire(cyc);
        total++; if (link_alive !== m_alive) begin bad++; $display("FAIL to_race_alive: got %b want %b", link_alive, m_alive); end
        total++; if (flags !== m_flags) begin bad++; $display("FAIL to_race_flags: got %b want %b", flags, m_flags); end
        total++; if (su_cnt !== m_pulses_upto(cyc - 1)) begin bad++; $display("FAIL to_race_pulses: got %0d want %0d", su_cnt, m_pulses_upto(cyc - 1)); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) send_byte(8'h01, 1);
        m_expire(cyc);
        total++; if (frame_count !== m_frames) begin bad++; $display("FAIL wrap_frames: got %0d want %0d", frame_count, m_frames); end
        total++; if (flags !== m_flags) begin bad++; $display("FAIL wrap_flags: got %b want %b", flags, m_flags); end
        total++; if (link_alive !== m_alive) begin bad++; $display("FAIL wrap_alive: got %b want %b", link_alive, m_alive); end
    endtask

    task automatic test_confirm();
        do_reset();
        send_byte(8'h05, 1);
        m_expire(cyc);
        total++; if (flags !== m_flags) begin bad++; $display("FAIL conf_first: got %b want %b", flags, m_flags); end
        send_byte(8'h09, 1);
        m_expire(cyc);
        total++; if (flags !== m_flags) begin bad++; $display("FAIL conf_second: got %b want %b", flags, m_flags); end
        send_byte(8'h09, 1);
        m_expire(cyc);
        total++; if (flags !== m_flags) begin bad++; $display("FAIL conf_third: got %b want %b", flags, m_flags); end
        total++; if (su_cnt !== m_pulses_upto(cyc - 1)) begin bad++; $display("FAIL conf_pulses: got %0d want %0d", su_cnt, m_pulses_upto(cyc - 1)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int kind;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 99);
            if (kind < 45)      b = {2'b00, 4'($urandom), 2'b01};
            else if (kind < 60) b = {2'($urandom_range(1, 3)), 4'($urandom), 2'b01};
            else                b = 8'($urandom);
            script_mode = ($urandom_range(0, 9) == 0);
            send_byte(b, $urandom_range(1, 3));
            script_mode = 1'b0;
            repeat ($urandom_range(0, 12)) @(negedge clock);
            m_expire(cyc);
            total++; if ({flags, link_alive, frame_count, error_count} !== {m_flags, m_alive, m_frames, m_errors}) begin
                bad++;
                $display("FAIL rand_state[%0d]: got f=%b a=%b fc=%0d ec=%0d want f=%b a=%b fc=%0d ec=%0d",
                         i, flags, link_alive, frame_count, error_count, m_flags, m_alive, m_frames, m_errors);
            end
            total++; if (su_cnt !== m_pulses_upto(cyc - 1)) begin bad++; $display("FAIL rand_pulses[%0d]: got %0d want %0d", i, su_cnt, m_pulses_upto(cyc - 1)); end
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h1D, 1);
        reset = 1'b1;
        m_reset(cyc + 1);
        @(negedge clock);
        total++; if ({flags, link_alive, frame_count, error_count} !== 21'h0) begin
            bad++; $display("FAIL mid_reset: got f=%b a=%b fc=%0d ec=%0d want all 0", flags, link_alive, frame_count, error_count);
        end
        // Valid already high when reset releases must not be decoded.
        dataOut_bits = 8'h3D; dataOut_valid = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        dataOut_valid = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (frame_count !== 8'h00) begin bad++; $display("FAIL release_frames: got %0d want 0", frame_count); end
        total++; if (link_alive !== 1'b0) begin bad++; $display("FAIL release_alive: got %b want 0", link_alive); end
        total++; if (flags !== 4'h0) begin bad++; $display("FAIL release_flags: got %b want 0000", flags); end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        test_reset();
        test_hold_decode();
        test_script_mode();
        test_malformed();
        test_timeout();
        test_wrap();
        test_confirm();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/feedback_decoder.md
Name: feedback_decoder

Overview:
- Receive-side counterpart of the command sender: decodes feedback bytes that the game sends through the UART (`io_dataOut_bits` / `io_dataOut_valid`) into registered status flags for control logic.
- Runs in the UART 16x clock domain. Sits between the UART module and the script/manual control logic.
- Also provides link-liveness supervision, frame and error counters, and an optional two-byte confirmation filter.

Parameters:
- TIMEOUT_CYCLES, 153600, cycles without a valid feedback frame before the link is declared lost (1 s at 153600 Hz).
- TMR_W, 18, width of the timeout counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clock  input  1  UART 16x baud clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- script_mode  input  1  high while ScriptMem is loading a script; incoming bytes are not feedback.
- dataOut_bits  input  8  byte from the UART receiver.
- dataOut_valid  input  1  byte-valid from the UART receiver; may stay high for more than one cycle.
- traveler_in_front_of_target_machine  output  1  feedback bit 2.
- traveler_has_item_in_hand  output  1  feedback bit 3.
- target_machine_is_processing  output  1  feedback bit 4.
- target_machine_has_item  output  1  feedback bit 5.
- status_update  output  1  one-cycle pulse when the four flags are (re)written.
- link_alive  output  1  high while feedback frames arrive within TIMEOUT_CYCLES.
- frame_count  output  8  accepted feedback frames, wraps 255 -> 0.
- error_count  output  8  malformed frames, saturates at 255.

Behaviour:
- Reset: all flag outputs 0, status_update 0, link_alive 0, frame_count 0, error_count 0, timeout counter 0, confirm state EMPTY, valid edge register 0.
- Byte strobe:
  - A byte is taken only on the rising edge of dataOut_valid (registered previous value), so each byte is decoded once regardless of pulse length.
  - Strobes while script_mode=1 are discarded entirely: no counters change and the timeout is not reloaded.
- Classification of a strobed byte b:
  - Feedback frame: b[1:0]=2'b01 and b[7:6]=2'b00.
  - Malformed: b[1:0]=2'b01 and b[7:6]≠0. Increments error_count (saturating); flags untouched.
  - All other b[1:0] values are not addressed to this block and are ignored silently.
- Accepted feedback frame (feature disabled):
  - Flags load b[5:2] on the cycle after the strobe (1-cycle latency from the strobe, 2 cycles from the valid rising edge).
  - status_update pulses in the same cycle the flags load.
  - frame_count increments by 1.
  - Timeout counter reloads to 0 and link_alive goes 1, all in that same cycle.
- Timeout / liveness:
  - While link_alive=1 and no feedback frame arrives, the counter increments each cycle.
  - When the counter reaches TIMEOUT_CYCLES-1: link_alive goes 0, all four flags clear to 0, status_update pulses once, and the counter holds.
  - A frame arriving on the same cycle as expiry wins: the link stays alive, the counter reloads, and the flags load from the frame.
  - While link_alive=0 the counter holds at 0.
- Counter boundaries:
  - frame_count wraps 255 -> 0.
  - error_count stays at 255 once saturated.
  - Counters are not cleared by timeout, only by reset.
- Reset asserted mid-operation: everything returns to reset values on the next clock edge. A valid pulse that is high during reset release is not decoded, because the edge register is forced to the current dataOut_valid on the first cycle after reset.

Optional Feature:
- Macro: FEEDBACK_CONFIRM_EN.
- When defined, a confirm FSM gates flag updates:
  - States: EMPTY and PENDING(candidate[3:0]).
  - EMPTY + feedback frame -> PENDING with candidate = b[5:2]; no flag update.
  - PENDING + frame with b[5:2]=candidate -> flags load, status_update pulses, state returns to EMPTY.
  - PENDING + differing frame -> stay PENDING with the new candidate.
  - Timeout or malformed byte -> EMPTY.
- Unaffected by the feature: frame_count and liveness still react to every feedback frame.
- When not defined: single-frame update as in Behaviour, and no confirm state is synthesised.

Test Plan:
- Reset release, byte 8'h3D (0011_1101) held valid for 3 cycles -> exactly one decode; all four flags = 1, status_update high for 1 cycle, frame_count=1, link_alive=1.
- script_mode=1, byte 8'h05 strobed -> flags, counters and link_alive unchanged.
- Byte 8'hC1 -> error_count=1, flags unchanged; send 300 malformed bytes -> error_count stays 255.
- Byte 8'h09, then no traffic for TIMEOUT_CYCLES (TIMEOUT_CYCLES=16 in bench) -> link_alive falls at cycle 16, flags clear, one status_update pulse; byte 8'h09 arriving exactly at the expiry cycle -> link stays alive.
- 256 bytes of 8'h01 -> frame_count wraps to 0, flags all 0, link_alive=1.
- With FEEDBACK_CONFIRM_EN: 8'h05, 8'h09, 8'h09 -> no update after the first two bytes; flags = 4'b0010 (only traveler_has_item_in_hand) after the third.
